// File: rtl/muldiv_pkg.sv
// Shared types for the multiply/divide sequencer: FSM states, op encoding
// and exception causes.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE,
        EXC
    } muldiv_state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic {
        EXC_DIVZERO,
        EXC_TIMEOUT
    } exc_cause_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequences one multiply or divide: start pulse, wait for the unit, write
// HI/LO and report completion, or raise a divide-by-zero/timeout exception.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic op_valid,
    input  logic op_div,
    input  logic flush,
    input  logic mult_end,
    input  logic div_end,
    input  logic div_zero,
    output logic op_ready,
    output logic busy,
    output logic start_mult,
    output logic start_div,
    output logic hilo_sel,
    output logic wr_hi,
    output logic wr_lo,
    output logic done,
    output logic exc_divzero,
    output logic exc_timeout
);

    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);

    muldiv_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_q, op_d;
    exc_cause_t    cause_q, cause_d;

    logic op_ready_q, op_ready_d;
    logic busy_q, busy_d;
    logic start_mult_q, start_mult_d;
    logic start_div_q, start_div_d;
    logic wr_q, wr_d;
    logic done_q, done_d;
    logic exc_divzero_q, exc_divzero_d;
    logic exc_timeout_q, exc_timeout_d;

    logic sel_end;
    assign sel_end = (op_q == OP_DIV) ? div_end : mult_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        cause_d = cause_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    op_d    = op_div;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = flush ? IDLE : WAIT;
            end
            WAIT: begin
                // Priority: flush, divide-by-zero, unit done, timeout.
                if (flush) begin
                    state_d = IDLE;
                end else if (op_q == OP_DIV && div_zero) begin
                    cause_d = EXC_DIVZERO;
                    state_d = EXC;
                end else if (sel_end) begin
                    state_d = WRITE;
                end else if (cnt_q == CNT_LAST) begin
                    cause_d = EXC_TIMEOUT;
                    state_d = EXC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WRITE:   state_d = flush ? IDLE : DONE;
            DONE:    state_d = IDLE;
            EXC:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        op_ready_d    = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
        start_mult_d  = (state_d == ISSUE) && (op_d == OP_MULT);
        start_div_d   = (state_d == ISSUE) && (op_d == OP_DIV);
        wr_d          = (state_d == WRITE);
        done_d        = (state_d == DONE);
        exc_divzero_d = (state_d == EXC) && (cause_d == EXC_DIVZERO);
        exc_timeout_d = (state_d == EXC) && (cause_d == EXC_TIMEOUT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= OP_MULT;
            cause_q       <= EXC_DIVZERO;
            op_ready_q    <= 1'b1;
            busy_q        <= 1'b0;
            start_mult_q  <= 1'b0;
            start_div_q   <= 1'b0;
            wr_q          <= 1'b0;
            done_q        <= 1'b0;
            exc_divzero_q <= 1'b0;
            exc_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            cause_q       <= cause_d;
            op_ready_q    <= op_ready_d;
            busy_q        <= busy_d;
            start_mult_q  <= start_mult_d;
            start_div_q   <= start_div_d;
            wr_q          <= wr_d;
            done_q        <= done_d;
            exc_divzero_q <= exc_divzero_d;
            exc_timeout_q <= exc_timeout_d;
        end
    end

    assign op_ready    = op_ready_q;
    assign busy        = busy_q;
    assign start_mult  = start_mult_q;
    assign start_div   = start_div_q;
    assign hilo_sel    = op_q;
    assign wr_hi       = wr_q;
    assign wr_lo       = wr_q;
    assign done        = done_q;
    assign exc_divzero = exc_divzero_q;
    assign exc_timeout = exc_timeout_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Random-stimulus bench for muldiv_ctrl: two instances (MAX_CYCLES 64 and 8)
// share inputs and are checked every cycle against a transaction timeline.
module tb_muldiv_ctrl;

    localparam int N  = 4000;
    localparam int NA = N + 200;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, op_valid, op_div, flush, mult_end, div_end, div_zero;

    logic [9:0] out_v [2];
    logic [9:0] exp_q [2][NA];

    bit rst_s [NA];
    bit vld_s [NA];
    bit dv_s  [NA];
    bit fl_s  [NA];
    bit me_s  [NA];
    bit de_s  [NA];
    bit dz_s  [NA];

    int n_checks = 0;
    int n_fail   = 0;

    muldiv_ctrl #(.MAX_CYCLES(64)) dut64 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_div(op_div),
        .flush(flush), .mult_end(mult_end), .div_end(div_end), .div_zero(div_zero),
        .op_ready(out_v[0][9]), .busy(out_v[0][8]), .start_mult(out_v[0][7]),
        .start_div(out_v[0][6]), .hilo_sel(out_v[0][5]), .wr_hi(out_v[0][4]),
        .wr_lo(out_v[0][3]), .done(out_v[0][2]), .exc_divzero(out_v[0][1]),
        .exc_timeout(out_v[0][0])
    );

    muldiv_ctrl #(.MAX_CYCLES(8)) dut8 (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_div(op_div),
        .flush(flush), .mult_end(mult_end), .div_end(div_end), .div_zero(div_zero),
        .op_ready(out_v[1][9]), .busy(out_v[1][8]), .start_mult(out_v[1][7]),
        .start_div(out_v[1][6]), .hilo_sel(out_v[1][5]), .wr_hi(out_v[1][4]),
        .wr_lo(out_v[1][3]), .done(out_v[1][2]), .exc_divzero(out_v[1][1]),
        .exc_timeout(out_v[1][0])
    );

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s observed=%b expected=%b (rdy,busy,sm,sd,sel,wh,wl,done,ezero,etmo)",
                     tag, obs, expv);
        end
    endtask

    // Output vector for each phase of an operation, given the latched op.
    function automatic logic [9:0] v_idle(input logic op);
        return {1'b1, 1'b0, 1'b0, 1'b0, op, 5'b0};
    endfunction
    function automatic logic [9:0] v_issue(input logic op);
        return {1'b0, 1'b1, ~op, op, op, 5'b0};
    endfunction
    function automatic logic [9:0] v_wait(input logic op);
        return {1'b0, 1'b1, 2'b0, op, 5'b0};
    endfunction
    function automatic logic [9:0] v_write(input logic op);
        return {1'b0, 1'b1, 2'b0, op, 2'b11, 3'b0};
    endfunction
    function automatic logic [9:0] v_done(input logic op);
        return {1'b0, 1'b1, 2'b0, op, 2'b00, 3'b100};
    endfunction
    function automatic logic [9:0] v_exc(input logic op, input bit tmo);
        return {1'b0, 1'b1, 2'b0, op, 3'b000, ~tmo, tmo};
    endfunction

    // Walk the stimulus one request at a time and lay out the expected
    // timeline: inputs of cycle c determine outputs seen in cycle c+1.
    task automatic build_expect(input int w, input int maxc);
        int t, s, k, i, x, txn;
        logic op;
        string outcome;
        for (int c = 0; c < NA; c++) exp_q[w][c] = '0;
        op = 1'b0;
        t = 0;
        txn = 0;
        while (t < N) begin
            if (rst_s[t]) begin
                op = 1'b0; exp_q[w][t+1] = v_idle(op); t++; continue;
            end
            if (!vld_s[t]) begin
                exp_q[w][t+1] = v_idle(op); t++; continue;
            end
            op = dv_s[t];
            s = t + 1;
            exp_q[w][s] = v_issue(op);
            txn++;
            x = -1;
            if (rst_s[s]) begin
                op = 1'b0; exp_q[w][s+1] = v_idle(op); t = s + 1; outcome = "reset";
            end else if (fl_s[s]) begin
                exp_q[w][s+1] = v_idle(op); t = s + 1; outcome = "flush";
            end else begin
                k = s + 1;
                i = 1;
                forever begin
                    exp_q[w][k] = v_wait(op);
                    if (rst_s[k]) begin
                        op = 1'b0; exp_q[w][k+1] = v_idle(op); t = k + 1; outcome = "reset"; break;
                    end
                    if (fl_s[k]) begin
                        exp_q[w][k+1] = v_idle(op); t = k + 1; outcome = "flush"; break;
                    end
                    if (op && dz_s[k]) begin
                        exp_q[w][k+1] = v_exc(op, 1'b0); x = k + 1; outcome = "divzero"; break;
                    end
                    if (op ? de_s[k] : me_s[k]) begin
                        exp_q[w][k+1] = v_write(op);
                        if (rst_s[k+1]) begin
                            op = 1'b0; exp_q[w][k+2] = v_idle(op); t = k + 2; outcome = "write+reset";
                        end else if (fl_s[k+1]) begin
                            exp_q[w][k+2] = v_idle(op); t = k + 2; outcome = "write+flush";
                        end else begin
                            exp_q[w][k+2] = v_done(op); x = k + 2; outcome = "done";
                        end
                        break;
                    end
                    if (i == maxc) begin
                        exp_q[w][k+1] = v_exc(op, 1'b1); x = k + 1; outcome = "timeout"; break;
                    end
                    i++;
                    k++;
                end
            end
            // Terminal one-cycle states always return to IDLE.
            if (x >= 0) begin
                if (rst_s[x]) op = 1'b0;
                exp_q[w][x+1] = v_idle(op);
                t = x + 1;
            end
            if (w == 0)
                $display("txn %0d max=%0d op=%s outcome=%s end_cycle=%0d",
                         txn, maxc, op ? "div" : "mult", outcome, t);
        end
    endtask

    initial begin
        int mode;
        for (int c = 0; c < NA; c++) begin
            mode = (c / 150) % 3;
            rst_s[c] = (c < N) && ((c < 3) || ($urandom_range(0, 299) == 0));
            vld_s[c] = (c < N) && ($urandom_range(0, 3) == 0);
            dv_s[c]  = ($urandom_range(0, 1) == 1);
            fl_s[c]  = (c < N) && ($urandom_range(0, 49) == 0);
            me_s[c]  = (c < N) && (mode != 2) && ($urandom_range(0, mode == 1 ? 39 : 14) == 0);
            de_s[c]  = (c < N) && (mode != 2) && ($urandom_range(0, mode == 1 ? 39 : 14) == 0);
            dz_s[c]  = (c < N) && (mode != 2) && ($urandom_range(0, 59) == 0);
        end
        build_expect(0, 64);
        build_expect(1, 8);

        for (int c = 0; c < N; c++) begin
            reset    = rst_s[c];
            op_valid = vld_s[c];
            op_div   = dv_s[c];
            flush    = fl_s[c];
            mult_end = me_s[c];
            div_end  = de_s[c];
            div_zero = dz_s[c];
            @(posedge clock);
            #1;
            check_eq($sformatf("max64 cyc%0d", c + 1), out_v[0], exp_q[0][c+1]);
            check_eq($sformatf("max8 cyc%0d", c + 1), out_v[1], exp_q[1][c+1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the multicycle CPU's multiplier and divider, and for the HI/LO write path.
- Accepts a mult/div request from the main control unit and issues a one-cycle start pulse to the selected unit.
- Waits for that unit's end flag, then writes HI/LO and reports completion.
- Reports divide-by-zero and hung-unit conditions as exceptions, without writing HI/LO.

Parameters:
- MAX_CYCLES, 64, maximum cycles spent in WAIT before a timeout exception (must be >= 2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  request from main control; sampled only in IDLE
- op_div  in  1  0 = mult, 1 = div; sampled with op_valid
- flush  in  1  abort any in-flight operation
- mult_end  in  1  multiplier finished
- div_end  in  1  divider finished
- div_zero  in  1  divider reports zero divisor
- op_ready  out  1  controller idle, can accept a request
- busy  out  1  operation in flight (not IDLE)
- start_mult  out  1  one-cycle start pulse to multiplier
- start_div  out  1  one-cycle start pulse to divider
- hilo_sel  out  1  HI/LO input mux select: 0 = multiplier, 1 = divider
- wr_hi  out  1  HI register load
- wr_lo  out  1  LO register load
- done  out  1  one-cycle completion pulse
- exc_divzero  out  1  one-cycle divide-by-zero exception pulse
- exc_timeout  out  1  one-cycle timeout exception pulse

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, and takes priority over everything.
- Reset values:
  - State = IDLE, counter = 0, latched op = 0.
  - hilo_sel = 0; all pulse outputs = 0; busy = 0; op_ready = 1.
- States: IDLE, ISSUE, WAIT, WRITE, DONE, EXC.
- IDLE:
  - op_ready = 1.
  - If op_valid: latch op_div into op_reg and go to ISSUE.
  - op_valid outside IDLE is ignored and not queued.
- ISSUE:
  - Assert start_mult (op_reg = 0) or start_div (op_reg = 1) for exactly this cycle.
  - Clear counter; go to WAIT.
  - End/zero flags are ignored this cycle.
- WAIT, evaluated each cycle in this priority order:
  1. flush → IDLE.
  2. op_reg = 1 and div_zero → EXC, cause divzero.
  3. Selected unit's end flag (mult_end for mult, div_end for div) → WRITE.
  4. counter == MAX_CYCLES-1 → EXC, cause timeout.
  5. Otherwise counter++ and stay in WAIT.
  - The non-selected unit's end flag is ignored; div_zero is ignored for mult.
- WRITE: wr_hi = wr_lo = 1 for one cycle; go to DONE.
- DONE: done = 1 for one cycle; go to IDLE.
- EXC:
  - Pulse exc_divzero or exc_timeout per the latched cause, for one cycle; go to IDLE.
  - No HI/LO write occurs.
- flush:
  - Effective in ISSUE, WAIT, WRITE and DONE: next state is IDLE.
  - If flush coincides with WRITE, that cycle's wr_hi/wr_lo still assert (already registered); done is suppressed.
  - flush has no effect in IDLE or EXC.
- hilo_sel equals op_reg at all times; it is stable from ISSUE through WRITE.
- Latency:
  - op_valid accepted at cycle 0 → start pulse at cycle 1.
  - End flag seen at WAIT cycle N → wr_hi/wr_lo at N+1 → done at N+2.
  - Minimum request-to-done is 4 cycles.
- Timeout: WAIT lasts at most MAX_CYCLES cycles. The counter is $clog2(MAX_CYCLES) bits wide and saturates logically via the compare.
- Reset mid-operation: next cycle is IDLE with all outputs at reset values. No partial write and no exception pulse.
- busy = (state != IDLE).

Decomposition:
- Package muldiv_pkg:
  - state enum muldiv_state_t {IDLE, ISSUE, WAIT, WRITE, DONE, EXC}.
  - Op constants OP_MULT = 1'b0, OP_DIV = 1'b1.
  - Exception-cause enum {EXC_DIVZERO, EXC_TIMEOUT}.
- Single module. No sub-module is needed; the counter is inline.

Test Plan:
1. Mult. Reset, then op_valid=1, op_div=0 at cycle 0; mult_end at WAIT cycle 32 → start_mult=1 only at cycle 1; hilo_sel=0; wr_hi=wr_lo=1 at cycle 34; done at cycle 35; op_ready=1 at cycle 36.
2. Div. op_div=1; div_end after 5 WAIT cycles → start_div pulse; hilo_sel=1 throughout; single wr_hi/wr_lo pulse; done follows; mult_end asserted during WAIT is ignored.
3. Divide-by-zero. div_zero and div_end in the same WAIT cycle → exc_divzero pulse next cycle; wr_hi, wr_lo and done never assert.
4. Timeout. MAX_CYCLES=8, op_div=0, no end flag → exc_timeout pulses in the cycle after the 8th WAIT cycle; no writes; op_ready returns high.
5. Flush and ignored request. flush and mult_end in the same WAIT cycle → IDLE next cycle, no wr/done. op_valid pulsed during WAIT is ignored (no second start pulse).
6. Reset mid-operation. Assert reset during WAIT → next cycle all pulse outputs 0, busy=0, op_ready=1, hilo_sel=0. A fresh mult then completes normally.
